seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Downstream display stage for the counter FSM. It takes the 8-bit indication value (N1/N2 entry value or sawtooth count) and the 2-bit state code. The value is converted to three BCD digits with a sequential shift-add-3 engine. The block then time-multiplexes four common-anode seven-segment digits: ones, tens, hundreds and state, with leading-zero blanking.

## Interface
Parameters:
- SCAN_DIV, default 4: clock cycles each digit stays enabled; legal range 1..65535.

Ports:
- clc_i, input, 1: system clock; all registers clock on the rising edge.
- rst_i, input, 1: reset, asynchronous, active-low.
- value_i, input, 8: binary value to display, 0..255.
- state_i, input, 2: FSM state code, shown on digit 3.
- seg_o, input/output direction is output, 8: segment drive {dp,g,f,e,d,c,b,a}, active-low, registered.
- an_o, output, 4: digit enables, active-low one-hot, registered; bit k selects digit k.
- bcd_out, output, 12: converted value {hundreds,tens,ones}, registered.
- busy_out, output, 1: high while a conversion is in progress.

## Operation
Conversion FSM has four states: IDLE, LOAD, SHIFT and DONE.
- IDLE: if value_i != conv_val, go to LOAD; otherwise stay in IDLE. busy_out is 0 only in IDLE.
- LOAD: conv_val<=value_i, sr<=value_i, bcd_work<=0, shift count<=0, then go to SHIFT.
- SHIFT: each nibble of bcd_work that is >=5 gets +3, evaluated on the pre-shift value. Then {bcd_work,sr} shifts left by 1. After the 8th SHIFT cycle, go to DONE.
- DONE: bcd_out<=bcd_work, then go to IDLE.
- value_i changes during LOAD/SHIFT/DONE are ignored. On return to IDLE the new mismatch is detected and the value is reconverted, so the last stable value always wins.
- Arithmetic: 12-bit BCD work register. The maximum result is 255 = 12'h255, so no overflow is possible.

Scanner:
- 16-bit prescaler counts 0..SCAN_DIV-1 and wraps.
- On wrap, the 2-bit digit index increments 0->1->2->3->0.
- Digit 0 shows ones, always visible.
- Digit 1 shows tens, blanked when hundreds=0 and tens=0.
- Digit 2 shows hundreds, blanked when hundreds=0.
- Digit 3 shows state_i as digit 0..3 with dp lit (code & 8'h7F).
- Active-low codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF.
- seg_o and an_o are registered from the current index and bcd_out. an_o = ~(4'b0001<<index).
- state_i is sampled live each cycle; there is no conversion delay for it.

## Timing
Reset values (asynchronous on rst_i low):
- FSM=IDLE, conv_val=0, bcd_out=0, busy_out=0.
- Prescaler=0, index=0, seg_o=8'hFF, an_o=4'hF (all off).

First clock after reset release: an_o=4'b1110, seg_o=C0.

Conversion latency:
- value_i changes and is seen in IDLE at edge t: LOAD at t+1, SHIFT t+2..t+9, DONE t+10.
- bcd_out is updated at edge t+11; busy_out is high for edges t+1..t+10.
- Display shows the new digits from the next registered seg_o update, at t+12.

Scan timing:
- Digit k is enabled for exactly SCAN_DIV cycles.
- Full refresh period is 4*SCAN_DIV cycles.
- SCAN_DIV=1 advances the digit every cycle.

Boundary conditions:
- rst_i asserted mid-conversion aborts immediately to the reset values; no partial bcd_out is committed.
- value_i=0 at reset release: no conversion starts, because conv_val already equals 0.
- Index 3->0 wrap and a bcd_out update on the same edge: the new bcd_out is used from the following cycle. The digit shown never mixes nibbles of two different values.

## Test plan
- Reset then release with value_i=0, SCAN_DIV=4: an_o cycles 1110,1101,1011,0111 every 4 clocks. seg_o is C0, FF, FF, then state digit with dp; busy_out never rises.
- value_i=8'd255 in IDLE: busy_out high for 10 cycles, bcd_out=12'h255 exactly 11 edges later. Digits show 5,5,2.
- value_i=8'd7 then 8'd40 and 8'd100 sequentially: bcd_out=007, 040, 100. Digit 1 is blank for 7; digit 1 shows 0 for 100.
- value_i 8'd10 changed to 8'd99 at SHIFT cycle 3: bcd_out=010 first, then a second conversion yields 099 with no intermediate value.
- rst_i pulsed low during SHIFT of value 200: all outputs return to reset values immediately. After release with value_i=200, bcd_out=200 after 11 cycles.
- state_i stepped 0..3 with SCAN_DIV=1: digit 3 shows 40, 79, 24, 30 (dp lit) on successive enables.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Binary-to-BCD display driver: sequential shift-add-3 converter feeding a
// four-digit common-anode scanner (ones, tens, hundreds, state code).
module seg7_scan_driver #(
    parameter int SCAN_DIV = 4
) (
    input  logic        clc_i,
    input  logic        rst_i,
    input  logic [7:0]  value_i,
    input  logic [1:0]  state_i,
    output logic [7:0]  seg_o,
    output logic [3:0]  an_o,
    output logic [11:0] bcd_out,
    output logic        busy_out
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [1:0]  fsm;
    logic [7:0]  conv_val;
    logic [7:0]  sr;
    logic [11:0] bcd_work;
    logic [2:0]  shift_cnt;
    logic [15:0] presc;
    logic [1:0]  idx;
    logic [7:0]  digit_code;
    logic [11:0] bcd_adj;

    // Add 3 to every nibble that is 5 or more, ahead of the left shift.
    function automatic logic [11:0] dabble_adj(input logic [11:0] b);
        logic [11:0] r;
        for (int n = 0; n < 3; n++) begin
            r[n*4 +: 4] = (b[n*4 +: 4] >= 4'd5) ? b[n*4 +: 4] + 4'd3 : b[n*4 +: 4];
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 8'hC0;
            4'd1:    seg_code = 8'hF9;
            4'd2:    seg_code = 8'hA4;
            4'd3:    seg_code = 8'hB0;
            4'd4:    seg_code = 8'h99;
            4'd5:    seg_code = 8'h92;
            4'd6:    seg_code = 8'h82;
            4'd7:    seg_code = 8'hF8;
            4'd8:    seg_code = 8'h80;
            4'd9:    seg_code = 8'h90;
            default: seg_code = 8'hFF;
        endcase
    endfunction

    assign busy_out = (fsm != S_IDLE);
    assign bcd_adj  = dabble_adj(bcd_work);

    always_ff @(posedge clc_i or negedge rst_i) begin
        if (!rst_i) begin
            fsm      <= S_IDLE;
            conv_val <= 8'd0;
            bcd_out  <= 12'd0;
        end else begin
            case (fsm)
                S_IDLE:  if (value_i != conv_val) fsm <= S_LOAD;
                S_LOAD: begin
                    conv_val <= value_i;
                    fsm      <= S_SHIFT;
                end
                S_SHIFT: if (shift_cnt == 3'd7) fsm <= S_DONE;
                default: begin
                    bcd_out <= bcd_work;
                    fsm     <= S_IDLE;
                end
            endcase
        end
    end

    // Working registers are always initialised in LOAD, so they carry no reset.
    always_ff @(posedge clc_i) begin
        if (fsm == S_LOAD) begin
            sr        <= value_i;
            bcd_work  <= 12'd0;
            shift_cnt <= 3'd0;
        end else if (fsm == S_SHIFT) begin
            {bcd_work, sr} <= {bcd_adj, sr} << 1;
            shift_cnt      <= shift_cnt + 3'd1;
        end
    end

    // Digit select: leading-zero blanking on tens and hundreds, dp lit on the state digit.
    always_comb begin
        digit_code = 8'hFF;
        case (idx)
            2'd0: digit_code = seg_code(bcd_out[3:0]);
            2'd1: digit_code = (bcd_out[11:4] == 8'd0) ? 8'hFF : seg_code(bcd_out[7:4]);
            2'd2: digit_code = (bcd_out[11:8] == 4'd0) ? 8'hFF : seg_code(bcd_out[11:8]);
            default: digit_code = seg_code({2'b00, state_i}) & 8'h7F;
        endcase
    end

    always_ff @(posedge clc_i or negedge rst_i) begin
        if (!rst_i) begin
            presc <= 16'd0;
            idx   <= 2'd0;
            seg_o <= 8'hFF;
            an_o  <= 4'hF;
        end else begin
            if (presc == DIV_LAST) begin
                presc <= 16'd0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + 16'd1;
            end
            seg_o <= digit_code;
            an_o  <= ~(4'b0001 << idx);
        end
    end

endmodule
